// File: rtl/partial_sum_accumulator_pkg.sv
// Shared constants and state encoding for the partial-sum accumulator.
package partial_sum_accumulator_pkg;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam int          FP_SIGN_BIT = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        BIAS  = 2'd2
    } state_t;
endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
// Subnormal inputs and results flush to zero; Inf/NaN propagate.
module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        AddBar_Sub,
    output logic [31:0] result
);
    logic              bs, sx, sy, sticky, found;
    logic [7:0]        ex, ey, d;
    logic [22:0]       fx, fy;
    logic [26:0]       mx, my, my_sh, norm;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [24:0]       rnd;
    logic signed [9:0] er;

    always_comb begin
        bs = b[31] ^ AddBar_Sub;
        // Order operands by magnitude so the mantissa subtract never goes negative.
        if (a[30:0] >= b[30:0]) begin
            sx = a[31]; ex = a[30:23]; fx = a[22:0];
            sy = bs;    ey = b[30:23]; fy = b[22:0];
        end else begin
            sx = bs;    ex = b[30:23]; fx = b[22:0];
            sy = a[31]; ey = a[30:23]; fy = a[22:0];
        end
        mx = (ex == 8'd0) ? 27'd0 : {1'b1, fx, 3'b000};
        my = (ey == 8'd0) ? 27'd0 : {1'b1, fy, 3'b000};
        d  = ex - ey;
        if (d >= 8'd27) begin
            my_sh  = 27'd0;
            sticky = |my;
        end else begin
            my_sh  = my >> d;
            sticky = |(my & ((27'd1 << d) - 27'd1));
        end
        my_sh[0] = my_sh[0] | sticky;
        sum = (sx == sy) ? ({1'b0, mx} + {1'b0, my_sh}) : ({1'b0, mx} - {1'b0, my_sh});

        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found && sum[i]) begin
                lz    = 5'(26 - i);
                found = 1'b1;
            end
        end

        er = signed'({2'b00, ex});
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            er   = er + 10'sd1;
        end else begin
            norm = sum[26:0] << lz;
            er   = er - signed'({5'b00000, lz});
        end

        rnd = {1'b0, norm[26:3]} + 25'(norm[2] & (norm[1] | norm[0] | norm[3]));
        if (rnd[24]) begin
            rnd = rnd >> 1;
            er  = er + 10'sd1;
        end

        result = {sx, er[7:0], rnd[22:0]};
        if (sum == 28'd0)
            result = (sx & sy) ? 32'h8000_0000 : 32'h0000_0000;
        else if (er >= 10'sd255)
            result = {sx, 8'hFF, 23'd0};
        else if (er <= 10'sd0)
            result = {sx, 31'd0};

        if (ex == 8'hFF) begin
            if (fx != 23'd0 || (ey == 8'hFF && sx != sy))
                result = 32'h7FC0_0000;
            else
                result = {sx, 8'hFF, 23'd0};
        end
    end
endmodule

// File: rtl/partial_sum_accumulator.sv
// Accumulates NUM_CHUNKS adder-tree partial sums, adds bias, emits one FP32 result.
// Define PARTIAL_SUM_RELU_EN to clamp negative results (sign bit set) to +0.
module partial_sum_accumulator
    import partial_sum_accumulator_pkg::*;
#(
    parameter int NUM_CHUNKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [31:0] bias,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        busy
);
    localparam int               CNT_W      = $clog2(NUM_CHUNKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_CHUNKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam state_t           FIRST_NEXT = (NUM_CHUNKS == 1) ? BIAS : ACCUM;

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_data_q, out_data_d;
    logic [31:0]        add_b, add_y, res_val;

    // Single adder shared between chunk accumulation and the bias add.
    assign add_b = (state_q == BIAS) ? bias : in_data;

    fp_adder u_fp_adder (
        .a          (acc_q),
        .b          (add_b),
        .AddBar_Sub (1'b0),
        .result     (add_y)
    );

    always_comb begin
`ifdef PARTIAL_SUM_RELU_EN
        res_val = add_y[FP_SIGN_BIT] ? FP_ZERO : add_y;
`else
        res_val = add_y;
`endif
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    cnt_d   = CNT_ONE;
                    state_d = FIRST_NEXT;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_y;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST)
                        state_d = BIAS;
                end
            end
            BIAS: begin
                out_valid_d = 1'b1;
                out_data_d  = res_val;
                // A beat landing here opens the next group without a bubble.
                if (in_valid) begin
                    acc_d   = in_data;
                    cnt_d   = CNT_ONE;
                    state_d = FIRST_NEXT;
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            acc_q       <= FP_ZERO;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= FP_ZERO;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q != IDLE);
endmodule
